// File: rtl/period_meter.sv
// Measures period and high time of an asynchronous square wave in clkin cycles.
// Define PERIOD_METER_HIGH_TIME_EN to build the high-time counter; otherwise high_time reads 0.
module period_meter #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 100000000,
  parameter int unsigned TOL     = 0
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             clr,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             locked,
  output logic             stable,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TOL_C     = CNT_W'(TOL);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  typedef enum logic {IDLE, MEASURE} state_e;

  state_e           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic             s1_d, s2_d, s3_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] prev_q, prev_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             period_valid_q, period_valid_d;
  logic             locked_q, locked_d;
  logic             stable_q, stable_d;
  logic             timeout_q, timeout_d;
  logic             rise;
  logic             load_one;
  logic             count_en;
  logic             publish;
  logic [CNT_W-1:0] diff;

  always_comb begin
    s1_d = sig_in;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  assign rise = s2_q & ~s3_q;
  assign diff = (cnt_q >= prev_q) ? (cnt_q - prev_q) : (prev_q - cnt_q);

  // clr overrides everything; a rise at cnt==TIMEOUT still publishes
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    prev_d         = prev_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    locked_d       = locked_q;
    stable_d       = stable_q;
    timeout_d      = timeout_q;
    load_one       = 1'b0;
    count_en       = 1'b0;
    publish        = 1'b0;
    if (clr) begin
      state_d   = IDLE;
      cnt_d     = '0;
      period_d  = '0;
      locked_d  = 1'b0;
      stable_d  = 1'b0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_d  = MEASURE;
            load_one = 1'b1;
          end
        end
        MEASURE: begin
          if (rise) begin
            publish        = 1'b1;
            load_one       = 1'b1;
            period_d       = cnt_q;
            period_valid_d = 1'b1;
            stable_d       = locked_q && (diff <= TOL_C);
            locked_d       = 1'b1;
            timeout_d      = 1'b0;
            prev_d         = cnt_q;
          end else if (cnt_q == TIMEOUT_C) begin
            state_d   = IDLE;
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            stable_d  = 1'b0;
          end else begin
            count_en = 1'b1;
          end
        end
      endcase
      if (load_one) begin
        cnt_d = ONE_C;
      end else if (count_en) begin
        cnt_d = cnt_q + ONE_C;
      end
    end
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      s1_q           <= 1'b0;
      s2_q           <= 1'b0;
      s3_q           <= 1'b0;
      cnt_q          <= '0;
      prev_q         <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      stable_q       <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      s1_q           <= s1_d;
      s2_q           <= s2_d;
      s3_q           <= s3_d;
      cnt_q          <= cnt_d;
      prev_q         <= prev_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      locked_q       <= locked_d;
      stable_q       <= stable_d;
      timeout_q      <= timeout_d;
    end
  end

`ifdef PERIOD_METER_HIGH_TIME_EN
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic [CNT_W-1:0] high_time_q, high_time_d;

  // hcnt starts at 1 because s2 is high in the rise cycle itself
  always_comb begin
    hcnt_d      = hcnt_q;
    high_time_d = high_time_q;
    if (clr) begin
      hcnt_d      = '0;
      high_time_d = '0;
    end else begin
      if (publish) begin
        high_time_d = hcnt_q;
      end
      if (load_one) begin
        hcnt_d = ONE_C;
      end else if (count_en) begin
        hcnt_d = hcnt_q + CNT_W'(s2_q);
      end
    end
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      hcnt_q      <= '0;
      high_time_q <= '0;
    end else begin
      hcnt_q      <= hcnt_d;
      high_time_q <= high_time_d;
    end
  end

  assign high_time = high_time_q;
`else
  assign high_time = '0;
`endif

  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign stable       = stable_q;
  assign timeout      = timeout_q;

endmodule
